// File: rtl/register_ownership_manager_if.sv
// Bus between the processors and the register ownership manager.
// Handshake: processor i holds boot_renew_register[i] with register_num[i]; claim_ack[i] pulses the cycle after the accepting edge, and a cycle without ack means the request was refused and must be retried.
interface register_ownership_manager_if #(
    parameter int NUM_PROC        = 2,
    parameter int REGISTER_AMOUNT = 32,
    parameter int REGISTER_WIDTH  = 64
);
    localparam int REG_NUM_W = $clog2(REGISTER_AMOUNT);
    localparam int PROC_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

    logic [REGISTER_WIDTH-1:0]  processor_registers [NUM_PROC][REGISTER_AMOUNT];
    logic [NUM_PROC-1:0]        processor_idle;
    logic [NUM_PROC-1:0]        boot_renew_register;
    logic [REG_NUM_W-1:0]       register_num [NUM_PROC];
    logic [REGISTER_WIDTH-1:0]  ra_register;

    logic [NUM_PROC-1:0]        claim_ack;
    logic [NUM_PROC-1:0]        synchronization_processor;
    logic                       synchronized_processors;
    logic [REGISTER_AMOUNT-1:0] processing_register_table;
    logic [PROC_W-1:0]          register_owner [REGISTER_AMOUNT];
    logic [REGISTER_WIDTH-1:0]  registers_renew [REGISTER_AMOUNT];
    // Debug view of the per-processor updater FSMs (1 = UPDATING).
    logic [NUM_PROC-1:0]        updater_busy;

    modport master (
        output processor_registers, processor_idle, boot_renew_register,
               register_num, ra_register,
        input  claim_ack, synchronization_processor, synchronized_processors,
               processing_register_table, register_owner, registers_renew,
               updater_busy
    );

    modport slave (
        input  processor_registers, processor_idle, boot_renew_register,
               register_num, ra_register,
        output claim_ack, synchronization_processor, synchronized_processors,
               processing_register_table, register_owner, registers_renew,
               updater_busy
    );
endinterface

// File: rtl/register_ownership_manager.sv
// Arbitrates per-register write ownership between processors, tracks the last writer of
// every register, and tells idle processors when to reload the coherent register view.
module register_ownership_manager #(
    parameter int NUM_PROC        = 2,
    parameter int REGISTER_AMOUNT = 32,
    parameter int REGISTER_WIDTH  = 64,
    parameter int RA_INDEX        = 1
) (
    input logic clk,
    input logic rst,
    register_ownership_manager_if.slave bus
);
    localparam int REG_NUM_W = $clog2(REGISTER_AMOUNT);
    localparam int PROC_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        UPDATING = 1'b1
    } upd_state_e;

    upd_state_e                 state_q   [NUM_PROC];
    upd_state_e                 state_d   [NUM_PROC];
    logic [REG_NUM_W-1:0]       held_q    [NUM_PROC];
    logic [REG_NUM_W-1:0]       held_d    [NUM_PROC];
    logic [PROC_W-1:0]          owner_q   [REGISTER_AMOUNT];
    logic [PROC_W-1:0]          owner_d   [REGISTER_AMOUNT];
    logic [REGISTER_AMOUNT-1:0] table_q, table_d;
    logic [NUM_PROC-1:0]        sync_done_q, sync_done_d;
    logic [NUM_PROC-1:0]        ack_q, ack_d;
    logic [NUM_PROC-1:0]        sync_pulse_q, sync_pulse_d;
    logic [NUM_PROC-1:0]        accept, rel, sync_elig;
    logic                       all_idle;

    // Request evaluation and sync eligibility, all from registered state.
    always_comb begin
        accept    = '0;
        rel       = '0;
        sync_elig = '0;
        all_idle  = 1'b1;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (state_q[i] != IDLE) all_idle = 1'b0;
        end
        for (int i = 0; i < NUM_PROC; i++) begin
            rel[i]    = (state_q[i] == UPDATING) && bus.processor_idle[i];
            accept[i] = (state_q[i] == IDLE) && bus.boot_renew_register[i] &&
                        !table_q[bus.register_num[i]] &&
                        (bus.register_num[i] != REG_NUM_W'(RA_INDEX));
            // Lower index wins a same-cycle collision on one register.
            for (int j = 0; j < i; j++) begin
                if (bus.boot_renew_register[j] &&
                    (bus.register_num[j] == bus.register_num[i]))
                    accept[i] = 1'b0;
            end
            // Any pending request blocks sync, so a claim always beats a reload.
            sync_elig[i] = !sync_done_q[i] && all_idle && bus.processor_idle[i] &&
                           !(|bus.boot_renew_register);
        end
    end

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        owner_d      = owner_q;
        table_d      = table_q;
        sync_done_d  = sync_done_q | sync_elig;
        ack_d        = accept;
        sync_pulse_d = sync_elig;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (rel[i]) begin
                state_d[i]         = IDLE;
                table_d[held_q[i]] = 1'b0;
                owner_d[held_q[i]] = PROC_W'(i);
            end
        end
        // A release never collides with an accept: accept needs the table bit clear.
        for (int i = 0; i < NUM_PROC; i++) begin
            if (accept[i]) begin
                state_d[i]                   = UPDATING;
                held_d[i]                    = bus.register_num[i];
                table_d[bus.register_num[i]] = 1'b1;
                sync_done_d                  = sync_done_d & (NUM_PROC'(1) << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                state_q[i] <= IDLE;
                held_q[i]  <= '0;
            end
            for (int r = 0; r < REGISTER_AMOUNT; r++) begin
                owner_q[r] <= '0;
            end
            table_q      <= '0;
            sync_done_q  <= '1;
            ack_q        <= '0;
            sync_pulse_q <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            owner_q      <= owner_d;
            table_q      <= table_d;
            sync_done_q  <= sync_done_d;
            ack_q        <= ack_d;
            sync_pulse_q <= sync_pulse_d;
        end
    end

    assign bus.claim_ack                 = ack_q;
    assign bus.synchronization_processor = sync_pulse_q;
    assign bus.synchronized_processors   = &sync_done_q;
    assign bus.processing_register_table = table_q;
    assign bus.register_owner            = owner_q;

    always_comb begin
        bus.updater_busy = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            bus.updater_busy[i] = (state_q[i] == UPDATING);
        end
    end

    // The return-address slot is never owned; it always reflects ra_register.
    for (genvar r = 0; r < REGISTER_AMOUNT; r++) begin : g_renew
        if (r == RA_INDEX) begin : g_ra
            assign bus.registers_renew[r] = bus.ra_register;
        end else begin : g_owned
            assign bus.registers_renew[r] = bus.processor_registers[owner_q[r]][r];
        end
    end
endmodule
